// File: rtl/gnt_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gnt_bus_pkg
// Shared types and helpers for the grant-driven bus controller.
//   - state_t      : burst sequencer states (IDLE, XFER, RELEASE)
//   - N_MASTERS    : number of requesting masters behind the arbiter
//   - ID_W         : width of a master index
//   - onehot_valid : true when a grant vector has exactly one bit set
//   - onehot_enc   : one-hot grant vector to master index
//   - onehot_dec   : master index to one-hot vector
// The one-hot helpers are also used by the arbiter's bench, so they stay
// free of any controller-specific state.
// -----------------------------------------------------------------------------
package gnt_bus_pkg;

    localparam int N_MASTERS = 4;
    localparam int ID_W      = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        XFER    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic onehot_valid(input logic [N_MASTERS-1:0] vec);
        logic [N_MASTERS-1:0] low_cleared;
        low_cleared = vec & (vec - 4'b0001);
        return (vec != 4'b0000) && (low_cleared == 4'b0000);
    endfunction

    // Encode a one-hot vector; anything that is not one-hot maps to 0 and is
    // expected to be screened with onehot_valid first.
    function automatic logic [ID_W-1:0] onehot_enc(input logic [N_MASTERS-1:0] vec);
        logic [ID_W-1:0] idx;
        case (vec)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Decode a master index back to its one-hot position.
    function automatic logic [N_MASTERS-1:0] onehot_dec(input logic [ID_W-1:0] idx);
        logic [N_MASTERS-1:0] vec;
        case (idx)
            2'd0:    vec = 4'b0001;
            2'd1:    vec = 4'b0010;
            2'd2:    vec = 4'b0100;
            2'd3:    vec = 4'b1000;
            default: vec = 4'b0000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/gnt_bus_ctrl_beat_counter.sv
// -----------------------------------------------------------------------------
// gnt_beat_counter
// Beat counter for one burst. On load the burst length is captured and the
// count restarts at zero; each accepted non-final beat increments the count.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   load   : capture len_in and clear the count (burst lock)
//   inc    : advance to the next beat
//   len_in : burst length minus one, valid while load is high
//   last   : current beat is the final one (count == captured length)
// The sequencer never increments on the final beat, so count cannot wrap
// even for an all-ones length.
// -----------------------------------------------------------------------------
module gnt_beat_counter #(
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [LENW-1:0] len_in,
    output logic            last
);

    localparam logic [LENW-1:0] CNT_ONE  = LENW'(1);
    localparam logic [LENW-1:0] CNT_ZERO = {LENW{1'b0}};

    logic [LENW-1:0] count_r;
    logic [LENW-1:0] len_r;

    // Count and length registers: load wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
            len_r   <= CNT_ZERO;
        end else if (load) begin
            count_r <= CNT_ZERO;
            len_r   <= len_in;
        end else if (inc) begin
            count_r <= count_r + CNT_ONE;
            len_r   <= len_r;
        end else begin
            count_r <= count_r;
            len_r   <= len_r;
        end
    end

    assign last = (count_r == len_r);

endmodule

// File: rtl/gnt_bus_ctrl.sv
// -----------------------------------------------------------------------------
// gnt_bus_ctrl
// Consumes the arbiter's registered one-hot grant, locks onto the granted
// master and moves a burst of M_LEN+1 beats from that master to the shared
// slave over a valid/ready handshake, then pulses DONE for that master.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   GNT     : one-hot grant from the arbiter (bit i = master i)
//   M_DATA  : packed master beat data, slice i = [i*DW +: DW]
//   M_LEN   : packed burst length minus one, slice i = [i*LENW +: LENW]
//   M_ACK   : one-hot, master i's current beat accepted this cycle
//   S_VALID : beat valid to the slave
//   S_DATA  : beat data (zero when no beat is offered)
//   S_ID    : index of the master owning the bus
//   S_LAST  : final beat of the burst
//   S_READY : slave accepts the beat when S_VALID & S_READY
//   DONE    : one-cycle pulse, master i's burst complete
//   BUSY    : sequencer is in XFER or RELEASE
//   ERR     : one-cycle pulse after a non-zero, non-one-hot grant in IDLE
// -----------------------------------------------------------------------------
module gnt_bus_ctrl
    import gnt_bus_pkg::*;
#(
    parameter int DW   = 8,
    parameter int LENW = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_MASTERS-1:0]      GNT,
    input  logic [N_MASTERS*DW-1:0]   M_DATA,
    input  logic [N_MASTERS*LENW-1:0] M_LEN,
    output logic [N_MASTERS-1:0]      M_ACK,
    output logic                      S_VALID,
    output logic [DW-1:0]             S_DATA,
    output logic [ID_W-1:0]           S_ID,
    output logic                      S_LAST,
    input  logic                      S_READY,
    output logic [N_MASTERS-1:0]      DONE,
    output logic                      BUSY,
    output logic                      ERR
);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [ID_W-1:0]        id_r;
    logic [N_MASTERS-1:0]   done_r;
    logic                   err_r;

    logic [ID_W-1:0]        gnt_enc_s;
    logic                   lock_s;
    logic                   inc_s;
    logic                   done_set_s;
    logic                   err_set_s;
    logic                   hs_s;
    logic                   last_s;
    logic                   s_valid_s;

    logic [DW-1:0]          m_data_arr_s [N_MASTERS];
    logic [LENW-1:0]        m_len_arr_s  [N_MASTERS];

    // Unpack the flat master buses so they can be indexed by master number.
    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign m_data_arr_s[gi] = M_DATA[gi*DW +: DW];
            assign m_len_arr_s[gi]  = M_LEN[gi*LENW +: LENW];
        end
    endgenerate

    assign gnt_enc_s = onehot_enc(GNT);
    assign s_valid_s = (state_r == XFER);
    assign hs_s      = s_valid_s & S_READY;

    gnt_beat_counter #(
        .LENW (LENW)
    ) u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (lock_s),
        .inc    (inc_s),
        .len_in (m_len_arr_s[gnt_enc_s]),
        .last   (last_s)
    );

    // Next-state and per-cycle control strobes of the burst sequencer.
    always_comb begin
        state_nxt_s = state_r;
        lock_s      = 1'b0;
        inc_s       = 1'b0;
        done_set_s  = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (GNT == 4'b0000) begin
                    state_nxt_s = IDLE;
                end else if (onehot_valid(GNT)) begin
                    lock_s      = 1'b1;
                    state_nxt_s = XFER;
                end else begin
                    // Illegal grant: flag it, but never lock onto a guess.
                    err_set_s   = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            XFER: begin
                // GNT is deliberately not looked at while locked.
                if (hs_s) begin
                    if (last_s) begin
                        done_set_s  = 1'b1;
                        state_nxt_s = RELEASE;
                    end else begin
                        inc_s       = 1'b1;
                        state_nxt_s = XFER;
                    end
                end else begin
                    state_nxt_s = XFER;
                end
            end
            RELEASE: begin
                // One dead cycle lets the arbiter see the dropped request
                // before its grant is re-evaluated in IDLE.
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, owner index and the registered DONE/ERR pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            id_r    <= 2'd0;
            done_r  <= 4'b0000;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (lock_s) begin
                id_r <= gnt_enc_s;
            end else begin
                id_r <= id_r;
            end
            done_r  <= done_set_s ? onehot_dec(id_r) : 4'b0000;
            err_r   <= err_set_s;
        end
    end

    assign S_VALID = s_valid_s;
    assign S_ID    = id_r;
    assign S_LAST  = s_valid_s & last_s;
    // Data mux on the registered owner; forced to zero when no beat is offered.
    assign S_DATA  = s_valid_s ? m_data_arr_s[id_r] : {DW{1'b0}};
    assign M_ACK   = onehot_dec(id_r) & {N_MASTERS{hs_s}};
    assign DONE    = done_r;
    assign ERR     = err_r;
    assign BUSY    = (state_r == XFER) || (state_r == RELEASE);

endmodule

// File: tb/tb_gnt_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gnt_bus_ctrl
// Directed bench for gnt_bus_ctrl. Inputs change 1 time unit after a rising
// edge and outputs are compared 1 time unit later. Control outputs are
// compared as one bundle {S_VALID, S_LAST, M_ACK, DONE, BUSY, ERR}; S_ID and
// S_DATA are compared while a beat is offered and under reset.
// -----------------------------------------------------------------------------
module tb_gnt_bus_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  GNT;
    logic [31:0] M_DATA;
    logic [15:0] M_LEN;
    logic [3:0]  M_ACK;
    logic        S_VALID;
    logic [7:0]  S_DATA;
    logic [1:0]  S_ID;
    logic        S_LAST;
    logic        S_READY;
    logic [3:0]  DONE;
    logic        BUSY;
    logic        ERR;

    int checks   = 0;
    int failures = 0;

    logic [11:0] obs;
    logic [11:0] e;
    logic [7:0]  exp_d;

    gnt_bus_ctrl #(.DW(8), .LENW(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .GNT     (GNT),
        .M_DATA  (M_DATA),
        .M_LEN   (M_LEN),
        .M_ACK   (M_ACK),
        .S_VALID (S_VALID),
        .S_DATA  (S_DATA),
        .S_ID    (S_ID),
        .S_LAST  (S_LAST),
        .S_READY (S_READY),
        .DONE    (DONE),
        .BUSY    (BUSY),
        .ERR     (ERR)
    );

    assign obs = {S_VALID, S_LAST, M_ACK, DONE, BUSY, ERR};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ev(input logic v, input logic l, input logic [3:0] ack,
                                       input logic [3:0] dn, input logic busy, input logic err);
        return {v, l, ack, dn, busy, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic [7:0] d, input logic [3:0] l);
        M_DATA[i*8 +: 8] = d;
        M_LEN[i*4 +: 4]  = l;
    endtask

    task automatic test_reset();
        reset = 1'b0; GNT = 4'b0000; S_READY = 1'b0;
        M_DATA = 32'h4433_2211; M_LEN = 16'h0000;
        #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", obs, e); end
        checks++; if (S_DATA !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", S_DATA); end
        checks++; if (S_ID !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", S_ID); end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (obs !== e) begin failures++; $display("FAIL reset_idle got=%b exp=%b", obs, e); end
    endtask

    task automatic test_single_beat();
        set_master(1, 8'hB1, 4'd0); S_READY = 1'b1; GNT = 4'b0010;
        tick(); #1;
        e = ev(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL single_xfer got=%b exp=%b", obs, e); end
        checks++; if (S_ID !== 2'd1) begin failures++; $display("FAIL single_id got=%0d exp=1", S_ID); end
        checks++; if (S_DATA !== 8'hB1) begin failures++; $display("FAIL single_data got=%h exp=b1", S_DATA); end
        tick(); GNT = 4'b0000; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL single_release got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL single_idle got=%b exp=%b", obs, e); end
    endtask

    task automatic test_stall();
        logic [5:0] pat;
        int beat;
        pat  = 6'b111001;
        beat = 0;
        set_master(3, 8'h30, 4'd3); S_READY = 1'b0; GNT = 4'b1000;
        tick();
        for (int c = 0; c < 6; c++) begin
            S_READY = pat[c];
            #1;
            e = ev(1'b1, (beat == 3), pat[c] ? 4'b1000 : 4'b0000, 4'b0000, 1'b1, 1'b0);
            exp_d = 8'(8'h30 + beat);
            checks++; if (obs !== e) begin failures++; $display("FAIL stall_ctl c=%0d got=%b exp=%b", c, obs, e); end
            checks++; if (S_DATA !== exp_d) begin failures++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, S_DATA, exp_d); end
            checks++; if (S_ID !== 2'd3) begin failures++; $display("FAIL stall_id c=%0d got=%0d exp=3", c, S_ID); end
            tick();
            if (pat[c]) begin
                beat++;
                M_DATA[31:24] = 8'(8'h30 + beat);
            end
        end
        GNT = 4'b0000; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL stall_release got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL stall_idle got=%b exp=%b", obs, e); end
    endtask

    task automatic test_illegal_gnt();
        S_READY = 1'b1; GNT = 4'b0101;
        tick();
        GNT = 4'b0001; set_master(0, 8'h0A, 4'd0); #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        checks++; if (obs !== e) begin failures++; $display("FAIL err_pulse got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL err_lock got=%b exp=%b", obs, e); end
        checks++; if (S_DATA !== 8'h0A) begin failures++; $display("FAIL err_data got=%h exp=0a", S_DATA); end
        tick(); GNT = 4'b0000; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL err_release got=%b exp=%b", obs, e); end
        tick();
    endtask

    task automatic test_gnt_ignored();
        set_master(0, 8'h40, 4'd2); set_master(3, 8'hC3, 4'd0); S_READY = 1'b1; GNT = 4'b0001;
        tick();
        GNT = 4'b1000;
        for (int b = 0; b < 3; b++) begin
            #1;
            e = ev(1'b1, (b == 2), 4'b0001, 4'b0000, 1'b1, 1'b0);
            exp_d = 8'(8'h40 + b);
            checks++; if (obs !== e) begin failures++; $display("FAIL ign_ctl b=%0d got=%b exp=%b", b, obs, e); end
            checks++; if (S_ID !== 2'd0) begin failures++; $display("FAIL ign_id b=%0d got=%0d exp=0", b, S_ID); end
            checks++; if (S_DATA !== exp_d) begin failures++; $display("FAIL ign_data b=%0d got=%h exp=%h", b, S_DATA, exp_d); end
            tick();
            M_DATA[7:0] = 8'(8'h40 + b + 1);
        end
        #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL ign_release got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL ign_idle got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL ign_m3_ctl got=%b exp=%b", obs, e); end
        checks++; if (S_ID !== 2'd3) begin failures++; $display("FAIL ign_m3_id got=%0d exp=3", S_ID); end
        checks++; if (S_DATA !== 8'hC3) begin failures++; $display("FAIL ign_m3_data got=%h exp=c3", S_DATA); end
        tick(); GNT = 4'b0000; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL ign_m3_release got=%b exp=%b", obs, e); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        set_master(1, 8'h50, 4'd3); S_READY = 1'b1; GNT = 4'b0010;
        tick(); #1;
        e = ev(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL rmid_beat0 got=%b exp=%b", obs, e); end
        tick();
        M_DATA[15:8] = 8'h51;
        reset = 1'b0; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL rmid_async got=%b exp=%b", obs, e); end
        checks++; if (S_DATA !== 8'h00) begin failures++; $display("FAIL rmid_data got=%h exp=00", S_DATA); end
        checks++; if (S_ID !== 2'd0) begin failures++; $display("FAIL rmid_id got=%0d exp=0", S_ID); end
        GNT = 4'b0000;
        tick();
        checks++; if (obs !== e) begin failures++; $display("FAIL rmid_hold got=%b exp=%b", obs, e); end
        reset = 1'b1; set_master(2, 8'h60, 4'd1); GNT = 4'b0100;
        tick(); #1;
        e = ev(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL rmid_fresh0 got=%b exp=%b", obs, e); end
        checks++; if (S_ID !== 2'd2) begin failures++; $display("FAIL rmid_fresh_id got=%0d exp=2", S_ID); end
        tick(); M_DATA[23:16] = 8'h61; #1;
        e = ev(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL rmid_fresh1 got=%b exp=%b", obs, e); end
        checks++; if (S_DATA !== 8'h61) begin failures++; $display("FAIL rmid_fresh_data got=%h exp=61", S_DATA); end
        tick(); GNT = 4'b0000; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL rmid_release got=%b exp=%b", obs, e); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_master(3, 8'h70, 4'd1); set_master(1, 8'h80, 4'd1); S_READY = 1'b1; GNT = 4'b1000;
        tick(); #1;
        e = ev(1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c1 got=%b exp=%b", obs, e); end
        checks++; if (S_DATA !== 8'h70) begin failures++; $display("FAIL b2b_c1_data got=%h exp=70", S_DATA); end
        tick(); M_DATA[31:24] = 8'h71; #1;
        e = ev(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c2 got=%b exp=%b", obs, e); end
        checks++; if (S_DATA !== 8'h71) begin failures++; $display("FAIL b2b_c2_data got=%h exp=71", S_DATA); end
        tick(); GNT = 4'b0010; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c3_release got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c4_idle got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c5 got=%b exp=%b", obs, e); end
        checks++; if (S_ID !== 2'd1) begin failures++; $display("FAIL b2b_c5_id got=%0d exp=1", S_ID); end
        checks++; if (S_DATA !== 8'h80) begin failures++; $display("FAIL b2b_c5_data got=%h exp=80", S_DATA); end
        tick(); M_DATA[15:8] = 8'h81; #1;
        e = ev(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c6 got=%b exp=%b", obs, e); end
        checks++; if (S_DATA !== 8'h81) begin failures++; $display("FAIL b2b_c6_data got=%h exp=81", S_DATA); end
        tick(); GNT = 4'b0000; #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c7_release got=%b exp=%b", obs, e); end
        tick(); #1;
        e = ev(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_c8_idle got=%b exp=%b", obs, e); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_stall();
        test_illegal_gnt();
        test_gnt_ignored();
        test_reset_mid_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gnt_bus_ctrl.md
Name: gnt_bus_ctrl

Overview:
- Downstream consumer of the 4-way fixed-priority arbiter's registered one-hot GNT[3:0].
- Locks onto the granted master and runs a burst of DW-bit beats from that master to a single shared slave using a valid/ready handshake.
- Pulses a per-master DONE at burst end so the master drops its REQ.
- Sits between the arbiter and the shared slave port; contains the data mux and the burst sequencer.

Parameters:
- DW, 8, data width per beat.
- LENW, 4, burst-length field width; a burst is M_LEN+1 beats (1..2^LENW).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- GNT  input  4  one-hot grant from the arbiter (bit i = master i).
- M_DATA  input  4*DW  packed master data; slice i = [i*DW +: DW].
- M_LEN  input  4*LENW  packed burst length-1 per master; sampled at lock.
- M_ACK  output  4  one-hot, high in the cycle master i's current beat is accepted.
- S_VALID  output  1  beat valid to slave.
- S_DATA  output  DW  beat data.
- S_ID  output  2  index of the master owning the bus.
- S_LAST  output  1  high with the final beat of a burst.
- S_READY  input  1  slave accepts the beat when S_VALID & S_READY.
- DONE  output  4  one-cycle pulse, bit i = master i's burst complete.
- BUSY  output  1  high in XFER and RELEASE.
- ERR  output  1  one-cycle pulse on an illegal (non-one-hot, non-zero) GNT in IDLE.

Behaviour:
- Reset (reset=0, asynchronous) drives state to IDLE and clears id, beat count and length registers. S_VALID, S_LAST, M_ACK, DONE, BUSY and ERR are all 0; S_ID=0; S_DATA=0.
- FSM states are IDLE, XFER and RELEASE.
- IDLE:
  - GNT==0: stay in IDLE.
  - GNT one-hot: register id=encode(GNT) and len=M_LEN[id]; clear the beat counter; go to XFER next cycle. GNT sampled at edge N gives S_VALID=1 from cycle N+1.
  - GNT non-zero and not one-hot: ERR=1 for the following cycle, stay in IDLE, no lock.
- XFER:
  - S_VALID=1.
  - S_DATA = M_DATA slice[id], a combinational mux on the registered id. The master holds its data until M_ACK.
  - S_ID=id.
  - S_LAST = (count==len).
  - M_ACK = onehot(id) & {4{S_VALID & S_READY}}, combinational.
  - On handshake: if count==len go to RELEASE, else count++.
  - S_READY=0 stalls indefinitely; all outputs hold.
  - GNT changes (including drop to 0 or a different master) are ignored while locked.
- RELEASE:
  - Lasts exactly one cycle: DONE[id]=1, S_VALID=0, BUSY=1, GNT ignored. Next state is IDLE.
  - Because the arbiter has one cycle of grant latency, a stale GNT is re-evaluated only in IDLE. The earliest next lock is 2 cycles after the last handshake.
- Length arithmetic: count is LENW bits and never wraps, since comparison to len ends the burst first. M_LEN = all-ones gives a 2^LENW-beat burst.
- Reset mid-burst: immediate abort, no DONE pulse, no further M_ACK.
- Throughput: with S_READY held high, one beat per cycle.

Decomposition:
- Shared package gnt_bus_pkg:
  - Enum state_t {IDLE, XFER, RELEASE}.
  - Constant N_MASTERS=4 and ID_W=2.
  - Function onehot_valid(4-bit) and function onehot_enc(4-bit)->2-bit, reused by the arbiter's bench.
- One natural sub-module, gnt_beat_counter: load/clear/increment of count, with last = (count==len).

Test Plan:
- GNT=4'b0010, M_LEN[1]=0, S_READY=1 -> one beat on the cycle after the grant with S_ID=1, S_LAST=1, M_ACK=4'b0010; DONE=4'b0010 the next cycle; BUSY back to 0 after that.
- GNT=4'b1000, M_LEN[3]=3, S_READY pattern 1,0,0,1,1,1 -> exactly 4 accepted beats carrying master 3's data sequence; S_LAST only on the 4th; M_ACK only on handshake cycles; DONE=4'b1000 once.
- In IDLE apply GNT=4'b0101 -> ERR=1 for one cycle, S_VALID stays 0, no DONE; then GNT=4'b0001 locks normally.
- Lock master 0 with M_LEN=2, then switch GNT to 4'b1000 mid-burst -> S_ID stays 0, all 3 beats from master 0, DONE=4'b0001; master 3 is locked only after returning to IDLE.
- Assert reset low during the 2nd beat of a 4-beat burst -> all outputs 0 asynchronously, no DONE; after release, GNT=4'b0100 starts a fresh burst from count 0.
- Back-to-back: master 3 then master 1, both M_LEN=1, S_READY=1 -> beats 3,3, then one RELEASE cycle, one IDLE cycle, then beats 1,1; DONE pulses 4'b1000 then 4'b0010.
